pipe_hazard_ctrl: RTL and testbench
===================================

// Module: pipe_hazard_ctrl
// PURPOSE
//  Consumer-side controller for the ID/EX pipeline register. It reads the ID/EX outputs
//  and the ID-stage source registers, then drives stall, flush and bubble controls into
//  the PC, IF/ID, ID/EX and EX/MEM registers.
//  It handles three events: load-use hazards, branch/jump redirects resolved in EX, and
//  multi-cycle data-memory waits.
//  It also keeps saturating stall and flush counters for performance debug.
// PARAMETERS
//  CNT_W        16   width of the stall and flush event counters (saturating)
//  MEM_TIMEOUT  64   MEM_WAIT cycles before o_mem_timeout is raised
// PORTS
//  clk               in   1   clock, rising edge
//  rst               in   1   synchronous reset, active-low (rst==0 resets on the clk edge)
//  id_rs1_addr       in   5   rs1 of the instruction currently in ID
//  id_rs2_addr       in   5   rs2 of the instruction currently in ID
//  id_uses_rs1       in   1   ID instruction reads rs1
//  id_uses_rs2       in   1   ID instruction reads rs2
//  ex_rd_addr        in   5   rd of the instruction in EX (ID/EX output)
//  ex_dmem_ren       in   1   EX instruction is a load (ID/EX o_dmem_ren_pipeline)
//  ex_redirect       in   1   EX resolved a taken branch, jump or jalr this cycle
//  mem_dmem_req      in   1   MEM-stage instruction accesses dmem (ren|wen)
//  i_dmem_ready      in   1   dmem completes the MEM-stage access this cycle
//  o_pc_stall        out  1   hold the PC
//  o_ifid_stall      out  1   hold IF/ID
//  o_ifid_flush      out  1   zero IF/ID
//  o_idex_stall      out  1   hold ID/EX
//  o_idex_flush      out  1   load a bubble (all-zero controls) into ID/EX
//  o_exmem_stall     out  1   hold EX/MEM
//  o_memwb_bubble    out  1   insert a bubble into MEM/WB
//  o_mem_timeout     out  1   sticky: a dmem wait exceeded MEM_TIMEOUT
//  o_stall_cnt       out  CNT_W  cycles with o_pc_stall=1
//  o_flush_cnt       out  CNT_W  redirect flushes applied
// BEHAVIOUR
//  States: RUN, MEM_WAIT. Register the state; all stall and flush outputs are
//   combinational from state and inputs, so they take effect in the same cycle.
//  Definitions:
//   hz = ex_dmem_ren & ex_rd_addr!=0 &
//        ((id_uses_rs1 & rs1==rd) | (id_uses_rs2 & rs2==rd))
//   wait = mem_dmem_req & ~i_dmem_ready
//  RUN:
//   - If wait: enter MEM_WAIT. Assert all of pc/ifid/idex/exmem stall plus memwb_bubble.
//     Wait takes priority over redirect and hz.
//   - Else if ex_redirect: assert ifid_flush and idex_flush; no stall. Redirect takes
//     priority over hz, because the hazarding ID instruction is squashed.
//   - Else if hz: assert pc_stall, ifid_stall and idex_flush for exactly one cycle.
//     The hz term clears the next cycle once the load moves to MEM.
//  MEM_WAIT:
//   - Hold every stall and memwb_bubble while wait stays true.
//   - Exiting (i_dmem_ready=1): outputs follow the RUN rules in that same cycle; next
//     state is RUN.
//   - ex_redirect seen during MEM_WAIT sets pend_redir. No flush is applied while stalled.
//   - On the exit cycle, if pend_redir|ex_redirect: apply the flush and clear pend_redir.
//  Timeout:
//   - wait_cnt counts MEM_WAIT cycles and resets to 0 on entering MEM_WAIT.
//   - When wait_cnt==MEM_TIMEOUT-1 and still waiting: set o_mem_timeout (sticky) and
//     keep stalling.
//  Counters:
//   - o_stall_cnt increments each cycle o_pc_stall=1.
//   - o_flush_cnt increments each cycle a redirect flush is applied.
//   - Both saturate at all-ones and never wrap.
//  Reset (rst==0):
//   - state=RUN; pend_redir, wait_cnt, o_mem_timeout and both counters = 0.
//   - All stall/flush/bubble outputs read 0 while in reset.
//   - Reset in the middle of MEM_WAIT abandons the wait; the pending redirect is lost.
//  rd==x0 never causes a hazard. A store in EX never causes a hazard.
// TESTING
//  1. lw x5 in EX, ID add uses rs1=x5 -> one cycle of pc_stall=ifid_stall=idex_flush=1;
//     next cycle all 0; o_stall_cnt=1.
//  2. lw x0 in EX, ID uses rs1=x0 -> no stall. Load in EX with rd=x5 and ID not using
//     x5 -> no stall.
//  3. ex_redirect=1 together with hz=1 -> ifid_flush=idex_flush=1, pc_stall=0;
//     o_flush_cnt=1.
//  4. mem_dmem_req=1 with ready low for 3 cycles -> 3 cycles of all stalls; redirect
//     pulse in cycle 2 -> flush appears on the ready cycle only; o_flush_cnt=1.
//  5. MEM_TIMEOUT=4, ready never asserted -> o_mem_timeout rises after the 4th wait cycle
//     and stays 1 after ready arrives.
//  6. rst=0 mid-MEM_WAIT with pend_redir set -> next cycle all outputs and counters 0,
//     state RUN, no flush.

Source files
------------

// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline-side bundle between the datapath and the hazard controller: ID/EX/MEM
// status coming in, stall/flush/bubble controls going back out.
interface pipe_hazard_ctrl_if;
   logic [4:0] id_rs1_addr;
   logic [4:0] id_rs2_addr;
   logic       id_uses_rs1;
   logic       id_uses_rs2;
   logic [4:0] ex_rd_addr;
   logic       ex_dmem_ren;
   logic       ex_redirect;
   logic       mem_dmem_req;
   logic       i_dmem_ready;
   logic       o_pc_stall;
   logic       o_ifid_stall;
   logic       o_ifid_flush;
   logic       o_idex_stall;
   logic       o_idex_flush;
   logic       o_exmem_stall;
   logic       o_memwb_bubble;

   // Datapath side: reports pipeline status, obeys the controls.
   modport master (
      output id_rs1_addr, id_rs2_addr, id_uses_rs1, id_uses_rs2, ex_rd_addr,
             ex_dmem_ren, ex_redirect, mem_dmem_req, i_dmem_ready,
      input  o_pc_stall, o_ifid_stall, o_ifid_flush, o_idex_stall, o_idex_flush,
             o_exmem_stall, o_memwb_bubble
   );

   // Controller side.
   modport slave (
      input  id_rs1_addr, id_rs2_addr, id_uses_rs1, id_uses_rs2, ex_rd_addr,
             ex_dmem_ren, ex_redirect, mem_dmem_req, i_dmem_ready,
      output o_pc_stall, o_ifid_stall, o_ifid_flush, o_idex_stall, o_idex_flush,
             o_exmem_stall, o_memwb_bubble
   );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Hazard controller for a 5-stage pipeline: load-use stalls, EX-resolved redirect
// flushes and data-memory wait stalls, with saturating stall/flush event counters.
module pipe_hazard_ctrl #(
   parameter int unsigned CNT_W       = 16,
   parameter int unsigned MEM_TIMEOUT = 64
) (
   input  logic               clk,
   input  logic               rst,
   pipe_hazard_ctrl_if.slave  bus,
   output logic               o_mem_timeout,
   output logic [CNT_W-1:0]   o_stall_cnt,
   output logic [CNT_W-1:0]   o_flush_cnt
);

   localparam int unsigned       WaitCntW = $clog2(MEM_TIMEOUT) + 1;
   localparam logic [WaitCntW-1:0] WaitLast = WaitCntW'(MEM_TIMEOUT - 1);

   typedef enum logic [0:0] {StRun, StMemWait} state_e;

   state_e              state_q, state_d;
   logic                pend_redir_q, pend_redir_d;
   logic [WaitCntW-1:0] wait_cnt_q, wait_cnt_d;
   logic                timeout_d;
   logic [CNT_W-1:0]    stall_cnt_d, flush_cnt_d;

   logic hz, mem_wait, stall_all, hz_stall, redir_flush;

   assign hz = bus.ex_dmem_ren && (bus.ex_rd_addr != 5'd0) &&
               ((bus.id_uses_rs1 && (bus.id_rs1_addr == bus.ex_rd_addr)) ||
                (bus.id_uses_rs2 && (bus.id_rs2_addr == bus.ex_rd_addr)));
   assign mem_wait = bus.mem_dmem_req & ~bus.i_dmem_ready;

   // Next state, wait bookkeeping and the combinational pipeline controls.
   always_comb begin
      state_d      = state_q;
      pend_redir_d = pend_redir_q;
      wait_cnt_d   = wait_cnt_q;
      timeout_d    = o_mem_timeout;
      stall_all    = 1'b0;
      hz_stall     = 1'b0;
      redir_flush  = 1'b0;

      if (mem_wait) begin
         // A dmem wait freezes everything and outranks redirect and load-use.
         stall_all = 1'b1;
         state_d   = StMemWait;
         if (state_q == StRun) begin
            wait_cnt_d = '0;
         end else begin
            // The redirecting instruction is held in EX; remember it for the exit cycle.
            if (bus.ex_redirect) pend_redir_d = 1'b1;
            if (wait_cnt_q == WaitLast) timeout_d = 1'b1;
            else                        wait_cnt_d = wait_cnt_q + WaitCntW'(1);
         end
      end else begin
         state_d      = StRun;
         pend_redir_d = 1'b0;
         // Redirect squashes the ID instruction, so its hazard no longer matters.
         if (bus.ex_redirect || pend_redir_q) redir_flush = 1'b1;
         else if (hz)                         hz_stall    = 1'b1;
      end

      bus.o_pc_stall     = rst & (stall_all | hz_stall);
      bus.o_ifid_stall   = rst & (stall_all | hz_stall);
      bus.o_ifid_flush   = rst & redir_flush;
      bus.o_idex_stall   = rst & stall_all;
      bus.o_idex_flush   = rst & (redir_flush | hz_stall);
      bus.o_exmem_stall  = rst & stall_all;
      bus.o_memwb_bubble = rst & stall_all;

      stall_cnt_d = o_stall_cnt;
      flush_cnt_d = o_flush_cnt;
      if (bus.o_pc_stall && !(&o_stall_cnt))   stall_cnt_d = o_stall_cnt + CNT_W'(1);
      if (bus.o_ifid_flush && !(&o_flush_cnt)) flush_cnt_d = o_flush_cnt + CNT_W'(1);
   end

   // State and counter registers, synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q       <= StRun;
         pend_redir_q  <= 1'b0;
         wait_cnt_q    <= '0;
         o_mem_timeout <= 1'b0;
         o_stall_cnt   <= '0;
         o_flush_cnt   <= '0;
      end else begin
         state_q       <= state_d;
         pend_redir_q  <= pend_redir_d;
         wait_cnt_q    <= wait_cnt_d;
         o_mem_timeout <= timeout_d;
         o_stall_cnt   <= stall_cnt_d;
         o_flush_cnt   <= flush_cnt_d;
      end
   end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: cycle table plus timeout and counter-saturation sequences.
module tb_pipe_hazard_ctrl;

   localparam logic [6:0] NONE  = 7'b0000000;
   // {pc_stall, ifid_stall, ifid_flush, idex_stall, idex_flush, exmem_stall, memwb_bubble}
   localparam logic [6:0] STALL = 7'b1101011;
   localparam logic [6:0] HZ    = 7'b1100100;
   localparam logic [6:0] FLUSH = 7'b0010100;

   typedef struct {
      string      name;
      logic       rst;
      logic [4:0] rs1;
      logic       u1;
      logic [4:0] rs2;
      logic       u2;
      logic [4:0] rd;
      logic       ren;
      logic       redir;
      logic       req;
      logic       rdy;
      logic [6:0] ctl;
      logic [3:0] scnt;
      logic [3:0] fcnt;
      logic       to;
      bit         chk_cnt;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       mem_timeout;
   logic [3:0] stall_cnt;
   logic [3:0] flush_cnt;

   int checks = 0;
   int errors = 0;
   vec_t sb_q[$];
   vec_t tbl[22];

   pipe_hazard_ctrl_if bus ();

   pipe_hazard_ctrl #(
      .CNT_W       (4),
      .MEM_TIMEOUT (4)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .bus           (bus),
      .o_mem_timeout (mem_timeout),
      .o_stall_cnt   (stall_cnt),
      .o_flush_cnt   (flush_cnt)
   );

   always #5 clk = ~clk;

   function automatic vec_t mk(input string nm, input logic r, input logic [4:0] rs1,
                               input logic u1, input logic [4:0] rs2, input logic u2,
                               input logic [4:0] rd, input logic ren, input logic redir,
                               input logic req, input logic rdy, input logic [6:0] ctl,
                               input logic [3:0] scnt, input logic [3:0] fcnt);
      vec_t v;
      v.name = nm; v.rst = r; v.rs1 = rs1; v.u1 = u1; v.rs2 = rs2; v.u2 = u2;
      v.rd = rd; v.ren = ren; v.redir = redir; v.req = req; v.rdy = rdy;
      v.ctl = ctl; v.scnt = scnt; v.fcnt = fcnt; v.to = 1'b0; v.chk_cnt = 1'b1;
      return v;
   endfunction

   task automatic cmp(input string nm, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic check_one();
      vec_t e;
      logic [6:0] ctl;
      e = sb_q.pop_front();
      ctl = {bus.o_pc_stall, bus.o_ifid_stall, bus.o_ifid_flush, bus.o_idex_stall,
             bus.o_idex_flush, bus.o_exmem_stall, bus.o_memwb_bubble};
      cmp({e.name, "_ctl"}, 16'(ctl), 16'(e.ctl));
      cmp({e.name, "_timeout"}, 16'(mem_timeout), 16'(e.to));
      if (e.chk_cnt) begin
         cmp({e.name, "_stall_cnt"}, 16'(stall_cnt), 16'(e.scnt));
         cmp({e.name, "_flush_cnt"}, 16'(flush_cnt), 16'(e.fcnt));
      end
   endtask

   // Drive one cycle of inputs, queue its expectation, then check before the rising edge.
   task automatic apply(input vec_t v);
      @(negedge clk);
      rst              = v.rst;
      bus.id_rs1_addr  = v.rs1;
      bus.id_uses_rs1  = v.u1;
      bus.id_rs2_addr  = v.rs2;
      bus.id_uses_rs2  = v.u2;
      bus.ex_rd_addr   = v.rd;
      bus.ex_dmem_ren  = v.ren;
      bus.ex_redirect  = v.redir;
      bus.mem_dmem_req = v.req;
      bus.i_dmem_ready = v.rdy;
      sb_q.push_back(v);
      #2;
      check_one();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      vec_t v;
      //           name          rst rs1 u1 rs2 u2 rd ren rdr req rdy ctl   S   F
      tbl[0]  = mk("reset_gate",  0,  5, 1,  0, 0, 5, 1,  0,  0,  0, NONE,  0,  0);
      tbl[1]  = mk("lu_rs1",      1,  5, 1,  0, 0, 5, 1,  0,  0,  0, HZ,    0,  0);
      tbl[2]  = mk("lu_after",    1,  0, 0,  0, 0, 0, 0,  0,  0,  0, NONE,  1,  0);
      tbl[3]  = mk("lu_x0",       1,  0, 1,  0, 0, 0, 1,  0,  0,  0, NONE,  1,  0);
      tbl[4]  = mk("lu_nomatch",  1,  6, 1,  5, 0, 5, 1,  0,  0,  0, NONE,  1,  0);
      tbl[5]  = mk("lu_rs2",      1,  0, 0,  7, 1, 7, 1,  0,  0,  0, HZ,    1,  0);
      tbl[6]  = mk("store_ex",    1,  0, 0,  7, 1, 7, 0,  0,  0,  0, NONE,  2,  0);
      tbl[7]  = mk("redir_hz",    1,  5, 1,  0, 0, 5, 1,  1,  0,  0, FLUSH, 2,  0);
      tbl[8]  = mk("redir_after", 1,  0, 0,  0, 0, 0, 0,  0,  0,  0, NONE,  2,  1);
      tbl[9]  = mk("mw_enter",    1,  0, 0,  0, 0, 0, 0,  0,  1,  0, STALL, 2,  1);
      tbl[10] = mk("mw_redir",    1,  0, 0,  0, 0, 0, 0,  1,  1,  0, STALL, 3,  1);
      tbl[11] = mk("mw_hold",     1,  0, 0,  0, 0, 0, 0,  0,  1,  0, STALL, 4,  1);
      tbl[12] = mk("mw_exit_fl",  1,  0, 0,  0, 0, 0, 0,  0,  1,  1, FLUSH, 5,  1);
      tbl[13] = mk("mw_after",    1,  0, 0,  0, 0, 0, 0,  0,  0,  0, NONE,  5,  2);
      tbl[14] = mk("mw2_enter",   1,  0, 0,  0, 0, 0, 0,  0,  1,  0, STALL, 5,  2);
      tbl[15] = mk("mw2_exit_hz", 1,  5, 1,  0, 0, 5, 1,  0,  1,  1, HZ,    6,  2);
      tbl[16] = mk("mw2_after",   1,  0, 0,  0, 0, 0, 0,  0,  0,  0, NONE,  7,  2);
      tbl[17] = mk("rs_enter",    1,  0, 0,  0, 0, 0, 0,  0,  1,  0, STALL, 7,  2);
      tbl[18] = mk("rs_redir",    1,  0, 0,  0, 0, 0, 0,  1,  1,  0, STALL, 8,  2);
      tbl[19] = mk("rs_reset",    0,  0, 0,  0, 0, 0, 0,  0,  1,  0, NONE,  9,  2);
      tbl[20] = mk("rs_no_flush", 1,  0, 0,  0, 0, 0, 0,  0,  1,  1, NONE,  0,  0);
      tbl[21] = mk("rs_idle",     1,  0, 0,  0, 0, 0, 0,  0,  0,  0, NONE,  0,  0);

      rst = 1'b0;
      bus.id_rs1_addr = '0; bus.id_rs2_addr = '0; bus.id_uses_rs1 = 1'b0;
      bus.id_uses_rs2 = 1'b0; bus.ex_rd_addr = '0; bus.ex_dmem_ren = 1'b0;
      bus.ex_redirect = 1'b0; bus.mem_dmem_req = 1'b0; bus.i_dmem_ready = 1'b0;
      repeat (2) @(posedge clk);

      for (int i = 0; i < 22; i++) apply(tbl[i]);

      // Endless wait: timeout appears after the 4th MEM_WAIT cycle; stall count saturates.
      for (int i = 0; i < 20; i++) begin
         v = mk("timeout_wait", 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, STALL, 0, 0);
         v.to = (i >= 5);
         v.chk_cnt = 1'b0;
         apply(v);
      end
      v = mk("timeout_exit", 1, 0, 0, 0, 0, 0, 0, 0, 1, 1, NONE, 0, 0);
      v.to = 1'b1; v.chk_cnt = 1'b0;
      apply(v);
      v = mk("stall_sat", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, NONE, 15, 0);
      v.to = 1'b1;
      apply(v);

      // Reset clears the sticky timeout; repeated redirects saturate the flush count.
      v = mk("reset2", 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, NONE, 15, 0);
      v.to = 1'b1;
      apply(v);
      for (int i = 0; i < 18; i++) begin
         v = mk("flush_run", 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, FLUSH, 0, 0);
         v.chk_cnt = 1'b0;
         apply(v);
      end
      apply(mk("flush_sat", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, NONE, 0, 15));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
